piso_frame_ctrl: RTL and testbench
==================================

# piso_frame_ctrl

Sequencer for the 4-bit parallel-in/serial-out shift register. Accepts parallel words over a valid/ready handshake and drives the register's `load`, `shift_dir` and `parallel_in` pins. Qualifies the register's `serial_out` stream with bit-valid and last-bit strobes, and enforces an inter-frame gap. Sits between the word source and the PISO, so downstream logic sees framed serial bits instead of a free-running shifter.

## Interface
- `WIDTH`, 4: word width; must match the PISO width.
- `GAP_CYCLES`, 1: idle cycles after the last bit before the next word is accepted; 0..15.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset; the same clock and reset drive the PISO.
- `in_valid`  in  1  word available.
- `in_ready`  out  1  controller can accept a word.
- `in_data`  in  WIDTH  word to serialise.
- `in_lsb_first`  in  1  bit order for this word; sampled at accept.
- `sr_load`  out  1  to PISO `load`.
- `sr_shift_dir`  out  1  to PISO `shift_dir`.
- `sr_parallel_in`  out  WIDTH  to PISO `parallel_in`.
- `sr_serial_out`  in  1  from PISO `serial_out`.
- `tx_bit`  out  1  serial bit; meaningful only while `tx_bit_valid`=1.
- `tx_bit_valid`  out  1  `tx_bit` carries a frame bit this cycle.
- `tx_last`  out  1  final bit of the frame.
- `busy`  out  1  frame in progress (any state except IDLE).
- `done`  out  1  one-cycle pulse after the final bit.

## Operation
- PISO contract:
  - When `load`=1 at an edge, the PISO loads `parallel_in`.
  - From the next cycle, `serial_out` presents one bit per cycle.
  - `shift_dir`=0 emits MSB first; `shift_dir`=1 emits LSB first.
  - The PISO shifts every cycle `load`=0; the controller qualifies bits and never stalls the PISO.
- States:
  - IDLE: `in_ready`=1. `in_valid`=1 at an edge latches `in_data` and `in_lsb_first` and moves to LOAD.
  - LOAD: one cycle. `sr_load`=1 and `sr_parallel_in`=latched word. Moves to SHIFT with the bit counter at 0.
  - SHIFT: exactly WIDTH cycles. `tx_bit`=`sr_serial_out` (passthrough), `tx_bit_valid`=1. Counter increments 0..WIDTH-1.
    - `tx_last`=1 at count WIDTH-1 (parity disabled only).
    - Then goes to PARITY if compiled in, else to GAP, or to IDLE if GAP_CYCLES=0.
  - GAP: GAP_CYCLES cycles, with all `tx_*` outputs at 0. Then IDLE.
- `sr_shift_dir` equals the latched `in_lsb_first` from LOAD through the end of the frame. It holds its last value in IDLE.
- `sr_parallel_in` holds the latched word; it is 0 after reset.
- `done` is registered. It pulses in the cycle immediately after the final bit, whether that cycle is in GAP or IDLE.
- `in_ready`=0 in every state except IDLE. A word offered mid-frame waits; it is neither dropped nor latched.
- `in_data` changes while `in_ready`=0 have no effect.
- `reset`=0 at an edge, including mid-frame:
  - state returns to IDLE and the counter clears;
  - `sr_load`, `sr_shift_dir`, `sr_parallel_in`, `tx_bit`, `tx_bit_valid`, `tx_last`, `done` and `busy` all go to 0;
  - the partial frame is abandoned with no `done` pulse.
- `in_ready`=1 from the first cycle after reset deasserts.

## Timing
- Handshake accepted in cycle 0.
- LOAD in cycle 1.
- Data bits in cycles 2..WIDTH+1.
- Parity bit, if enabled, in cycle WIDTH+2.
- `done` in the cycle after the last bit.
- Next accept possible GAP_CYCLES cycles after the `done` cycle.
- With WIDTH=4, GAP_CYCLES=1 and no parity:
  - bits in cycles 2-5;
  - `done` and GAP in cycle 6;
  - `in_ready`=1 in cycle 7;
  - throughput one word per 7 cycles.
- With GAP_CYCLES=0, `in_ready` is high in the `done` cycle, so back-to-back frames are possible.

## Configuration
- `PISO_FRAME_CTRL_PARITY_EN` defined:
  - PARITY state of one cycle after SHIFT;
  - `tx_bit` = XOR of the latched word (even parity), with `tx_bit_valid`=1 and `tx_last`=1;
  - `tx_last` is not asserted on the final data bit;
  - frame is WIDTH+1 bits.
- Undefined: no PARITY state or logic; frame is WIDTH bits.

## Test plan
- Reset held low for 2 cycles, then released: all outputs 0 during reset; `in_ready`=1 and `busy`=0 in the cycle after release.
- `in_data`=1011, `in_lsb_first`=0: `sr_load` pulses in cycle 1; `tx_bit` sequence is 1,0,1,1 in cycles 2-5 with `tx_last` in cycle 5; `done` in cycle 6; `in_ready` returns in cycle 7.
- `in_data`=1101, `in_lsb_first`=1: `sr_shift_dir`=1 throughout the frame; `tx_bit` sequence is 1,0,1,1; `in_valid` held during the frame does not re-accept until IDLE.
- `reset` driven low in cycle 3 of a frame: next cycle is IDLE with `tx_bit_valid`=0, no `done` pulse, and `sr_load`=0.
- With `PISO_FRAME_CTRL_PARITY_EN`, `in_data`=1011: 5 valid bits; bit 5 is 1 with `tx_last`=1; `done` one cycle later.
- GAP_CYCLES=0 with continuous `in_valid`: words 1011 and 0110 are accepted back-to-back, giving a 6-cycle period with no overlap of `tx_bit_valid` from the two frames.

Source files
------------

// File: rtl/piso_frame_ctrl.sv
// Frame sequencer for a WIDTH-bit PISO: valid/ready word intake, load/direction control,
// bit-valid/last qualification and an inter-frame gap. Define PISO_FRAME_CTRL_PARITY_EN to append an even-parity bit.
module piso_frame_ctrl #(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_lsb_first,
  output logic             sr_load,
  output logic             sr_shift_dir,
  output logic [WIDTH-1:0] sr_parallel_in,
  input  logic             sr_serial_out,
  output logic             tx_bit,
  output logic             tx_bit_valid,
  output logic             tx_last,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LAST = 4'(GAP_CYCLES - 1);

`ifdef PISO_FRAME_CTRL_PARITY_EN
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, PARITY, GAP} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, GAP} state_t;
`endif

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    gap_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      gap_cnt        <= '0;
      in_ready       <= 1'b0;
      sr_load        <= 1'b0;
      sr_shift_dir   <= 1'b0;
      sr_parallel_in <= '0;
      tx_bit_valid   <= 1'b0;
      tx_last        <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      sr_load <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (in_ready && in_valid) begin
            sr_parallel_in <= in_data;
            sr_shift_dir   <= in_lsb_first;
            sr_load        <= 1'b1;
            in_ready       <= 1'b0;
            busy           <= 1'b1;
            state          <= LOAD;
          end else begin
            in_ready <= 1'b1;
          end
        end
        LOAD: begin
          cnt          <= '0;
          tx_bit_valid <= 1'b1;
`ifdef PISO_FRAME_CTRL_PARITY_EN
          tx_last      <= 1'b0;
`else
          tx_last      <= (LAST_CNT == '0);
`endif
          state        <= SHIFT;
        end
        SHIFT: begin
          if (cnt == LAST_CNT) begin
`ifdef PISO_FRAME_CTRL_PARITY_EN
            tx_last <= 1'b1;
            state   <= PARITY;
`else
            tx_bit_valid <= 1'b0;
            tx_last      <= 1'b0;
            done         <= 1'b1;
            gap_cnt      <= '0;
            if (GAP_CYCLES == 0) begin
              in_ready <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              state <= GAP;
            end
`endif
          end else begin
            cnt <= cnt + CW'(1);
`ifndef PISO_FRAME_CTRL_PARITY_EN
            tx_last <= (cnt + CW'(1) == LAST_CNT);
`endif
          end
        end
`ifdef PISO_FRAME_CTRL_PARITY_EN
        PARITY: begin
          tx_bit_valid <= 1'b0;
          tx_last      <= 1'b0;
          done         <= 1'b1;
          gap_cnt      <= '0;
          if (GAP_CYCLES == 0) begin
            in_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            state <= GAP;
          end
        end
`endif
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            in_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data bits pass straight through from the PISO; the parity bit is generated locally.
`ifdef PISO_FRAME_CTRL_PARITY_EN
  assign tx_bit = tx_bit_valid & ((state == PARITY) ? ^sr_parallel_in : sr_serial_out);
`else
  assign tx_bit = tx_bit_valid & sr_serial_out;
`endif

endmodule

// File: tb/tb_piso_frame_ctrl.sv
// Scoreboard bench for piso_frame_ctrl: two controllers (GAP_CYCLES 1 and 0), each driving a behavioural PISO.
module tb_piso_frame_ctrl;

`ifdef PISO_FRAME_CTRL_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic clk, rst_n;
  logic v0, rdy0, lsb0, ld0, dir0, so0, tb0, tv0, tl0, bz0, dn0;
  logic v1, rdy1, lsb1, ld1, dir1, so1, tb1, tv1, tl1, bz1, dn1;
  logic [3:0] d0, pin0, d1, pin1, reg0, reg1;
  logic [1:0] q0[$], q1[$];
  logic pl0 = 1'b0, pl1 = 1'b0;
  int n_vec = 0, n_err = 0;

  piso_frame_ctrl #(.WIDTH(4), .GAP_CYCLES(1)) u0 (
    .clk(clk), .reset(rst_n), .in_valid(v0), .in_ready(rdy0), .in_data(d0),
    .in_lsb_first(lsb0), .sr_load(ld0), .sr_shift_dir(dir0), .sr_parallel_in(pin0),
    .sr_serial_out(so0), .tx_bit(tb0), .tx_bit_valid(tv0), .tx_last(tl0),
    .busy(bz0), .done(dn0));

  piso_frame_ctrl #(.WIDTH(4), .GAP_CYCLES(0)) u1 (
    .clk(clk), .reset(rst_n), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
    .in_lsb_first(lsb1), .sr_load(ld1), .sr_shift_dir(dir1), .sr_parallel_in(pin1),
    .sr_serial_out(so1), .tx_bit(tb1), .tx_bit_valid(tv1), .tx_last(tl1),
    .busy(bz1), .done(dn1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural PISOs: load on sr_load, otherwise shift every cycle.
  always @(posedge clk) begin
    if (!rst_n) begin
      reg0 <= 4'd0;
      reg1 <= 4'd0;
    end else begin
      if (ld0) reg0 <= pin0; else if (dir0) reg0 <= reg0 >> 1; else reg0 <= reg0 << 1;
      if (ld1) reg1 <= pin1; else if (dir1) reg1 <= reg1 >> 1; else reg1 <= reg1 << 1;
    end
  end
  assign so0 = dir0 ? reg0[0] : reg0[3];
  assign so1 = dir1 ? reg1[0] : reg1[3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int inst, input logic [3:0] w, input bit lsb, input int nb);
    logic [1:0] e;
    int total;
    total = nb + ((nb == 4) ? PB : 0);
    for (int i = 0; i < total; i++) begin
      if (i < 4) e[1] = lsb ? w[i] : w[3-i];
      else       e[1] = ^w;
      e[0] = (i == total - 1) && (nb == 4);
      if (inst == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  // Monitor: pops the expected bit whenever a bit is presented; done must follow the last bit.
  always @(negedge clk) begin
    logic [1:0] e;
    if (tv0) begin
      if (q0.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL u0 unexpected bit: got %0b expected none", tb0);
      end else begin
        e = q0.pop_front();
        chk("u0 tx_bit", 32'(tb0), 32'(e[1]));
        chk("u0 tx_last", 32'(tl0), 32'(e[0]));
      end
    end
    if (dn0 || pl0) chk("u0 done after last", 32'(dn0), 32'(pl0));
    pl0 = tv0 & tl0;
    if (tv1) begin
      if (q1.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL u1 unexpected bit: got %0b expected none", tb1);
      end else begin
        e = q1.pop_front();
        chk("u1 tx_bit", 32'(tb1), 32'(e[1]));
        chk("u1 tx_last", 32'(tl1), 32'(e[0]));
      end
    end
    if (dn1 || pl1) chk("u1 done after last", 32'(dn1), 32'(pl1));
    pl1 = tv1 & tl1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst_n = 1'b0;
    v0 = 0; d0 = 4'd0; lsb0 = 0;
    v1 = 0; d1 = 4'd0; lsb1 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst in_ready", 32'(rdy0), 0);
    chk("rst busy", 32'(bz0), 0);
    chk("rst sr_load", 32'(ld0), 0);
    chk("rst sr_shift_dir", 32'(dir0), 0);
    chk("rst sr_parallel_in", 32'(pin0), 0);
    chk("rst tx_bit_valid", 32'(tv0), 0);
    chk("rst tx_last", 32'(tl0), 0);
    chk("rst done", 32'(dn0), 0);
    chk("rst tx_bit", 32'(tb0), 0);
    chk("rst u1 in_ready", 32'(rdy1), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst in_ready", 32'(rdy0), 1);
    chk("post-rst busy", 32'(bz0), 0);

    // Frame 1011 MSB first
    d0 = 4'b1011; lsb0 = 0; v0 = 1; push(0, 4'b1011, 0, 4);
    @(negedge clk); v0 = 0;
    chk("f1 sr_load c1", 32'(ld0), 1);
    chk("f1 sr_parallel_in", 32'(pin0), 32'hB);
    chk("f1 in_ready c1", 32'(rdy0), 0);
    chk("f1 busy c1", 32'(bz0), 1);
    chk("f1 tx_bit_valid c1", 32'(tv0), 0);
    for (int k = 2; k <= 5 + PB; k++) begin
      @(negedge clk);
      chk("f1 tx_bit_valid", 32'(tv0), 1);
      chk("f1 sr_load low", 32'(ld0), 0);
    end
    @(negedge clk);
    chk("f1 done", 32'(dn0), 1);
    chk("f1 valid off", 32'(tv0), 0);
    chk("f1 in_ready in gap", 32'(rdy0), 0);
    chk("f1 busy in gap", 32'(bz0), 1);
    @(negedge clk);
    chk("f1 in_ready back", 32'(rdy0), 1);
    chk("f1 busy idle", 32'(bz0), 0);
    chk("f1 done once", 32'(dn0), 0);

    // Frame 1101 LSB first, in_valid held; mid-frame data change must be ignored
    d0 = 4'b1101; lsb0 = 1; v0 = 1; push(0, 4'b1101, 1, 4);
    for (int k = 1; k <= 6 + PB; k++) begin
      @(negedge clk);
      chk("f2 sr_shift_dir", 32'(dir0), 1);
      chk("f2 in_ready low", 32'(rdy0), 0);
      chk("f2 sr_parallel_in held", 32'(pin0), 32'hD);
      if (k == 3) begin d0 = 4'b0110; lsb0 = 0; end
    end
    @(negedge clk);
    chk("f2 in_ready re-open", 32'(rdy0), 1);
    chk("f2 dir held in idle", 32'(dir0), 1);
    push(0, 4'b0110, 0, 4);
    @(negedge clk); v0 = 0;
    chk("f3 sr_load", 32'(ld0), 1);
    chk("f3 sr_parallel_in", 32'(pin0), 32'h6);
    chk("f3 sr_shift_dir", 32'(dir0), 0);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = rdy0;
    end
    chk("f3 return to idle", 32'(seen), 1);

    // Reset mid-frame: reset low during cycle 3
    d0 = 4'b0110; lsb0 = 0; v0 = 1; push(0, 4'b0110, 0, 2);
    @(negedge clk); v0 = 0;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    chk("mrst tx_bit_valid", 32'(tv0), 0);
    chk("mrst sr_load", 32'(ld0), 0);
    chk("mrst done", 32'(dn0), 0);
    chk("mrst busy", 32'(bz0), 0);
    chk("mrst sr_parallel_in", 32'(pin0), 0);
    chk("mrst tx_last", 32'(tl0), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst in_ready after", 32'(rdy0), 1);
    chk("mrst no done", 32'(dn0), 0);

    // GAP_CYCLES=0: back-to-back 1011 then 0110 with continuous in_valid
    chk("b2b in_ready", 32'(rdy1), 1);
    d1 = 4'b1011; lsb1 = 0; v1 = 1;
    push(1, 4'b1011, 0, 4); push(1, 4'b0110, 0, 4);
    @(negedge clk);
    chk("b2b sr_load 1", 32'(ld1), 1);
    d1 = 4'b0110;
    for (int k = 2; k <= 5 + PB; k++) begin
      @(negedge clk);
      chk("b2b tx_bit_valid", 32'(tv1), 1);
      chk("b2b in_ready low", 32'(rdy1), 0);
    end
    @(negedge clk);
    chk("b2b in_ready at done", 32'(rdy1), 1);
    chk("b2b done", 32'(dn1), 1);
    chk("b2b no overlap", 32'(tv1), 0);
    @(negedge clk); v1 = 0;
    chk("b2b sr_load 2", 32'(ld1), 1);
    chk("b2b sr_parallel_in 2", 32'(pin1), 32'h6);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = rdy1;
    end
    chk("b2b return to idle", 32'(seen), 1);
    repeat (3) @(negedge clk);
    chk("u0 queue drained", 32'(q0.size()), 0);
    chk("u1 queue drained", 32'(q1.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
